aes_key_expand_ctrl: RTL

Sequencer for AES-128 key expansion. Takes a 128-bit cipher key and produces round keys 0..NUM_ROUNDS, one 32-bit word per cycle, with the round-constant XOR done internally. Shares one external 4-byte S-box (SubWord) with the rest of the core. Delivers each round key to the round datapath over a valid/ready handshake.

---
 rtl/aes_key_expand_ctrl_if.sv | 22 ++
 rtl/aes_key_expand_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_ctrl_if.sv
// Round-key delivery channel: producer (master) offers a 128-bit round key
// with its round index under a valid/ready handshake; consumer (slave) accepts.
interface aes_key_expand_ctrl_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  modport master (
    output rk_valid,
    output rk_data,
    output rk_round,
    input  rk_ready
  );

  modport slave (
    input  rk_valid,
    input  rk_data,
    input  rk_round,
    output rk_ready
  );
endinterface

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key expansion sequencer. Expands one 32-bit word per cycle in place
// over w0..w3, borrowing a shared external S-box for SubWord(RotWord(w3)), and
// hands each round key 0..NUM_ROUNDS to the round datapath over valid/ready.
// Optional macro AES_KEY_STORE_EN adds a round-key store with a combinational
// read port (rd_idx/rd_data) so decryption can replay keys without re-expanding.
module aes_key_expand_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [127:0]                 key_in,
  output logic                         busy,
  output logic [31:0]                  sub_in,
  input  logic [31:0]                  sub_out,
  aes_key_expand_ctrl_if.master        rk_if,
  output logic                         done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]                   rd_idx,
  output logic [127:0]                 rd_data
`endif
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {StIdle, StOut, StExpand} state_e;

  state_e      state_q;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic [3:0]  round_q;
  logic [1:0]  idx_q;
  logic        busy_q, valid_q, done_q;

  // Round constants only exist for rounds 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign sub_in           = {w3_q[23:0], w3_q[31:24]};
  assign busy             = busy_q;
  assign done             = done_q;
  assign rk_if.rk_valid   = valid_q;
  assign rk_if.rk_data    = {w0_q, w1_q, w2_q, w3_q};
  assign rk_if.rk_round   = round_q;

  // Candidate new words; each uses the registered (already updated) lower word.
  always_comb begin
    w0_d = w0_q ^ sub_out ^ {rcon(round_q), 24'h0};
    w1_d = w1_q ^ w0_q;
    w2_d = w2_q ^ w1_q;
    w3_d = w3_q ^ w2_q;
  end

  // Control FSM with registered busy/valid/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            {w0_q, w1_q, w2_q, w3_q} <= key_in;
            round_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StOut;
          end
        end
        StOut: begin
          if (rk_if.rk_ready) begin
            valid_q <= 1'b0;
            if (round_q == LastRound) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              round_q <= round_q + 4'd1;
              idx_q   <= '0;
              state_q <= StExpand;
            end
          end
        end
        StExpand: begin
          case (idx_q)
            2'd0:    w0_q <= w0_d;
            2'd1:    w1_q <= w1_d;
            2'd2:    w2_q <= w2_d;
            default: w3_q <= w3_d;
          endcase
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            valid_q <= 1'b1;
            state_q <= StOut;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [127:0] store_q [NUM_ROUNDS+1];

  // Capture each round key as it is handed off; a fresh start wipes old keys.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
    end else if (state_q == StIdle && start) begin
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
    end else if (state_q == StOut && rk_if.rk_ready) begin
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
        if (round_q == 4'(i)) store_q[i] <= {w0_q, w1_q, w2_q, w3_q};
      end
    end
  end

  // Out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_idx == 4'(i)) rd_data = store_q[i];
    end
  end
`endif

endmodule
